fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter AW, default 17, frame-buffer address width in bits.
REQ-002 Parameter DW, default 8, pixel data width in bits.
REQ-003 Parameter NPIX, default 19200, number of valid pixel addresses (0..NPIX-1); NPIX SHALL be at most 2**AW-1.
REQ-004 The block SHALL have one clock, clk, and one reset, rst, which is asynchronous and active-low.
REQ-005 clk  in  1  system clock; all state is updated on its rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 r0_valid/r0_addr/r0_data  in  1/AW/DW  requester 0 (camera capture) write request.
REQ-008 r0_ready  out  1  requester 0 request accepted this cycle.
REQ-009 r1_valid/r1_addr/r1_data  in  1/AW/DW  requester 1 (pixel processing) write request.
REQ-010 r1_ready  out  1  requester 1 request accepted this cycle.
REQ-011 clr_start  in  1  single-cycle pulse that starts a buffer clear.
REQ-012 clr_data  in  DW  fill value, sampled on the cycle clr_start is accepted.
REQ-013 clr_busy/clr_done  out  1/1  clear in progress / one-cycle completion pulse.
REQ-014 fb_addr/fb_data/fb_we  out  AW/DW/1  frame-buffer write port (address, data, write enable).
REQ-015 drop  out  1  one-cycle pulse: an accepted request was discarded because its address was out of range.

Function
REQ-016 The FSM SHALL have two states, ARB and CLEAR; the state after reset SHALL be ARB.
REQ-017 A transfer on requester N SHALL occur when rN_valid and rN_ready are both 1 in the same cycle.
REQ-018 rN_ready SHALL be combinational from the valid inputs, the state, clr_start and the last-grant flag.
REQ-019 In ARB, at most one ready SHALL be high per cycle.
REQ-020 In ARB with clr_start=0 and only one valid high, that requester's ready SHALL be 1.
REQ-021 In ARB with both valids high, the requester not granted last SHALL be granted (round-robin); the last-grant flag SHALL update on every transfer.
REQ-022 A transfer SHALL produce fb_we=1, fb_addr=rN_addr and fb_data=rN_data on the next cycle (latency 1, registered outputs).
REQ-023 If an accepted rN_addr >= NPIX, fb_we SHALL stay 0 on the next cycle and drop SHALL pulse 1 on that cycle.
REQ-024 In ARB, clr_start=1 SHALL force both readys to 0 in that cycle, latch clr_data and move the FSM to CLEAR.
REQ-025 In CLEAR, both readys SHALL be 0 and clr_start SHALL be ignored.
REQ-026 In CLEAR, the block SHALL write the latched fill value to addresses 0..NPIX-1, one address per cycle in ascending order, with fb_we=1 on every cycle.
REQ-027 On the cycle the write to address NPIX-1 is driven, the FSM SHALL return to ARB.
REQ-028 clr_done SHALL pulse on the first cycle after that last write.
REQ-029 clr_busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-030 Address 2**AW-1 (reserved black pixel) SHALL never be written.
REQ-031 Requests held pending during CLEAR SHALL be granted normally once the FSM is back in ARB; no request is lost or duplicated.
REQ-032 fb_we SHALL be 0 on any cycle with no transfer and no clear write.

Reset
REQ-033 Asserting rst, including mid-clear, SHALL immediately force: state=ARB, fb_we=0, fb_addr=0, fb_data=0, clr_busy=0, clr_done=0, drop=0, clear counter=0, last-grant=requester 1 (so requester 0 wins the first tie).
REQ-034 A clear interrupted by reset SHALL NOT resume after reset is released.

Structure
REQ-035 The state encoding (ARB, CLEAR) and the default NPIX value SHALL be defined in a shared package.
REQ-036 The round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs: two valids and the last-grant flag; output: a one-hot grant).
REQ-037 The clear address counter SHALL remain inline in fb_write_arbiter.

Verification
REQ-038 r0_valid=1, addr=5, data=0xAA, r1 idle -> r0_ready=1; next cycle fb_we=1, fb_addr=5, fb_data=0xAA.
REQ-039 r0 and r1 valid for 4 cycles after reset -> grants alternate r0,r1,r0,r1; fb_we=1 on 4 consecutive cycles.
REQ-040 clr_start with clr_data=0x1F while r1_valid=1 -> r1_ready=0; 19200 writes of 0x1F to addresses 0..19199; clr_done pulses once; r1 granted in the first ARB cycle after.
REQ-041 r1_addr=19200 accepted -> fb_we stays 0 and drop=1 on the next cycle.
REQ-042 rst asserted at clear address 100 -> outputs zero immediately; after release, clr_busy=0 and an r0 request is granted.
REQ-043 Scoreboard over random traffic -> fb_addr never equals 2**AW-1, and every accepted in-range request appears exactly once on the write port.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and defaults for the frame-buffer write arbiter.
// Pulled in by the arbiter top and its round-robin grant sub-block.
package fb_write_arbiter_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  localparam int NPIX_DEFAULT = 19200;

  // Last-grant flag encoding: which requester won the previous transfer.
  localparam logic LG_R0 = 1'b0;
  localparam logic LG_R1 = 1'b1;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester
// that did not win the previous transfer.
module rr_arb2
  import fb_write_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    unique case (i_valid)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: o_grant = (i_last == LG_R1) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write port shared by capture and processing requesters,
// with a full-buffer clear sequence that pre-empts both.
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int AW   = 17,
  parameter int DW   = 8,
  parameter int NPIX = NPIX_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_data,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_data,
  output logic          r1_ready,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] fb_addr,
  output logic [DW-1:0] fb_data,
  output logic          fb_we,
  output logic          drop
);

  localparam logic [AW-1:0] LP_NPIX = AW'(NPIX);
  localparam logic [AW-1:0] LP_LAST = AW'(NPIX - 1);

  fb_state_e     r_state;
  logic          r_last;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_fill;
  logic          r_done_pend;
  logic          r_fb_we;
  logic [AW-1:0] r_fb_addr;
  logic [DW-1:0] r_fb_data;
  logic          r_drop;
  logic          r_clr_busy;
  logic          r_clr_done;

  logic [1:0]    w_grant;
  logic          w_arb_en;
  logic          w_xfer0;
  logic          w_xfer1;
  logic          w_xfer;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_inrange;

  rr_arb2 u_rr_arb2 (
    .i_valid ({r1_valid, r0_valid}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  // A clear request steals the cycle from both requesters.
  assign w_arb_en  = (r_state == ST_ARB) && !clr_start;
  assign r0_ready  = w_arb_en & w_grant[0];
  assign r1_ready  = w_arb_en & w_grant[1];

  assign w_xfer0   = r0_valid & r0_ready;
  assign w_xfer1   = r1_valid & r1_ready;
  assign w_xfer    = w_xfer0 | w_xfer1;
  assign w_addr    = w_xfer1 ? r1_addr : r0_addr;
  assign w_data    = w_xfer1 ? r1_data : r0_data;
  assign w_inrange = (w_addr < LP_NPIX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ARB;
      r_last      <= LG_R1;
      r_cnt       <= '0;
      r_fill      <= '0;
      r_done_pend <= 1'b0;
      r_fb_we     <= 1'b0;
      r_fb_addr   <= '0;
      r_fb_data   <= '0;
      r_drop      <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_fb_we     <= 1'b0;
      r_drop      <= 1'b0;
      r_done_pend <= 1'b0;
      r_clr_done  <= r_done_pend;
      unique case (r_state)
        ST_ARB: begin
          if (clr_start) begin
            r_fill     <= clr_data;
            r_cnt      <= '0;
            r_state    <= ST_CLEAR;
            r_clr_busy <= 1'b1;
          end else if (w_xfer) begin
            r_last <= w_xfer1 ? LG_R1 : LG_R0;
            // Address port holds on a drop so it never shows junk.
            if (w_inrange) begin
              r_fb_we   <= 1'b1;
              r_fb_addr <= w_addr;
              r_fb_data <= w_data;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          r_fb_we   <= 1'b1;
          r_fb_addr <= r_cnt;
          r_fb_data <= r_fill;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST) begin
            r_cnt       <= '0;
            r_state     <= ST_ARB;
            r_clr_busy  <= 1'b0;
            r_done_pend <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fb_we    = r_fb_we;
  assign fb_addr  = r_fb_addr;
  assign fb_data  = r_fb_data;
  assign drop     = r_drop;
  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: expected writes are queued
// when a transfer or clear is accepted and popped at the write port.
module tb_fb_write_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 8;
  localparam int NPIX = 19200;
  localparam logic [AW-1:0] RSV = '1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          r0_valid, r1_valid;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_data, r1_data;
  logic          r0_ready, r1_ready;
  logic          clr_start;
  logic [DW-1:0] clr_data;
  logic          clr_busy, clr_done;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;
  logic          fb_we;
  logic          drop;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  wr_t m_e;

  fb_write_arbiter #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_addr   (r0_addr),
    .r0_data   (r0_data),
    .r0_ready  (r0_ready),
    .r1_valid  (r1_valid),
    .r1_addr   (r1_addr),
    .r1_data   (r1_data),
    .r1_ready  (r1_ready),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_we     (fb_we),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if ({fb_we, fb_addr, fb_data, clr_busy, clr_done, drop} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b a=%h d=%h busy=%b done=%b drop=%b want all 0",
               fb_we, fb_addr, fb_data, clr_busy, clr_done, drop);
    end
    total++;
    if ({r1_ready, r0_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready got=%b want=00", {r1_ready, r0_ready});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    r0_valid = 1'b1; r0_addr = 17'd5; r0_data = 8'hAA;
    #1;
    total++;
    if ({r1_ready, r0_ready} !== 2'b01) begin
      bad++;
      $display("FAIL single_ready got=%b want=01", {r1_ready, r0_ready});
    end
    if (r0_ready === 1'b1) exp_q.push_back('{a: 17'd5, d: 8'hAA});
    @(negedge clk);
    r0_valid = 1'b0;
    total++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 17'd5, 8'hAA}) begin
      bad++;
      $display("FAIL single_write got we=%b a=%0d d=%h want we=1 a=5 d=aa",
               fb_we, fb_addr, fb_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (fb_we !== 1'b1) begin
          bad++;
          $display("FAIL b2b_we cycle=%0d got=%b want=1", i, fb_we);
        end
      end
      r0_valid = 1'b1; r0_addr = AW'(10 + i); r0_data = DW'(8'h10 + i);
      r1_valid = 1'b1; r1_addr = AW'(20 + i); r1_data = DW'(8'h20 + i);
      #1;
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if ({r1_ready, r0_ready} !== want) begin
        bad++;
        $display("FAIL b2b_grant cycle=%0d got=%b want=%b",
                 i, {r1_ready, r0_ready}, want);
      end
      if (r0_ready === 1'b1) exp_q.push_back('{a: r0_addr, d: r0_data});
      if (r1_ready === 1'b1) exp_q.push_back('{a: r1_addr, d: r1_data});
    end
    @(negedge clk);
    r0_valid = 1'b0; r1_valid = 1'b0;
    total++;
    if (fb_we !== 1'b1) begin
      bad++;
      $display("FAIL b2b_we cycle=4 got=%b want=1", fb_we);
    end
    @(negedge clk);
    total++;
    if (fb_we !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_we got=%b want=0", fb_we);
    end
  endtask

  task automatic test_clear();
    bit got;
    int done_cnt;
    int busy_rdy;
    @(negedge clk);
    r1_valid = 1'b1; r1_addr = 17'd77; r1_data = 8'h33;
    clr_start = 1'b1; clr_data = 8'h1F;
    #1;
    total++;
    if ({r1_ready, r0_ready} !== 2'b00) begin
      bad++;
      $display("FAIL clr_start_ready got=%b want=00", {r1_ready, r0_ready});
    end
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{a: AW'(i), d: 8'h1F});
    got = 1'b0; done_cnt = 0; busy_rdy = 0;
    for (int cyc = 0; cyc < NPIX + 20 && !got; cyc++) begin
      @(negedge clk);
      clr_start = (cyc == 50);
      if (cyc == 50) clr_data = 8'h55;
      #1;
      if (cyc == 0) begin
        total++;
        if (clr_busy !== 1'b1) begin
          bad++;
          $display("FAIL clr_busy_start got=%b want=1", clr_busy);
        end
      end
      if (clr_done === 1'b1) done_cnt++;
      if (clr_busy === 1'b1 && (r0_ready !== 1'b0 || r1_ready !== 1'b0))
        busy_rdy++;
      if (r1_ready === 1'b1) begin
        got = 1'b1;
        total++;
        if ({fb_we, fb_addr, clr_busy} !== {1'b1, AW'(NPIX - 1), 1'b0}) begin
          bad++;
          $display("FAIL clr_last_write got we=%b a=%0d busy=%b want we=1 a=%0d busy=0",
                   fb_we, fb_addr, clr_busy, NPIX - 1);
        end
        exp_q.push_back('{a: 17'd77, d: 8'h33});
      end
    end
    clr_start = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL clr_r1_grant got=timeout want=grant");
    end
    @(negedge clk);
    r1_valid = 1'b0;
    total++;
    if ({clr_done, clr_busy} !== 2'b10) begin
      bad++;
      $display("FAIL clr_done_pulse got done=%b busy=%b want done=1 busy=0",
               clr_done, clr_busy);
    end
    if (clr_done === 1'b1) done_cnt++;
    repeat (4) begin
      @(negedge clk);
      if (clr_done === 1'b1) done_cnt++;
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL clr_done_count got=%0d want=1", done_cnt);
    end
    total++;
    if (busy_rdy != 0) begin
      bad++;
      $display("FAIL clr_ready_blocked got=%0d want=0", busy_rdy);
    end
  endtask

  task automatic test_drop();
    @(negedge clk);
    r1_valid = 1'b1; r1_addr = AW'(NPIX); r1_data = 8'h77;
    #1;
    total++;
    if (r1_ready !== 1'b1) begin
      bad++;
      $display("FAIL drop_ready got=%b want=1", r1_ready);
    end
    @(negedge clk);
    r1_valid = 1'b0;
    total++;
    if ({fb_we, drop} !== 2'b01) begin
      bad++;
      $display("FAIL drop_pulse got we=%b drop=%b want we=0 drop=1", fb_we, drop);
    end
    @(negedge clk);
    total++;
    if (drop !== 1'b0) begin
      bad++;
      $display("FAIL drop_clear got=%b want=0", drop);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit found;
    int busy_seen;
    @(negedge clk);
    clr_start = 1'b1; clr_data = 8'hC3;
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{a: AW'(i), d: 8'hC3});
    @(negedge clk);
    clr_start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_addr === 17'd100) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rstclr_reach got=timeout want=addr100");
    end
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if ({fb_we, fb_addr, fb_data, clr_busy, clr_done, drop} !== '0) begin
      bad++;
      $display("FAIL rstclr_outputs got we=%b a=%h d=%h busy=%b done=%b drop=%b want all 0",
               fb_we, fb_addr, fb_data, clr_busy, clr_done, drop);
    end
    @(negedge clk);
    rst = 1'b1;
    r0_valid = 1'b1; r0_addr = 17'd9; r0_data = 8'h5A;
    #1;
    total++;
    if ({r0_ready, clr_busy} !== 2'b10) begin
      bad++;
      $display("FAIL rstclr_grant got ready=%b busy=%b want ready=1 busy=0",
               r0_ready, clr_busy);
    end
    if (r0_ready === 1'b1) exp_q.push_back('{a: 17'd9, d: 8'h5A});
    busy_seen = 0;
    @(negedge clk);
    r0_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (clr_busy !== 1'b0) busy_seen++;
    end
    total++;
    if (busy_seen != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rstclr_no_resume got busy=%0d pend=%0d want 0 0",
               busy_seen, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic       exp_last;
    logic [1:0] want;
    int         exp_drop;
    int         seen_drop;
    int         sel;
    pulse_reset();
    exp_last = 1'b1; exp_drop = 0; seen_drop = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (drop === 1'b1) seen_drop++;
      r0_valid = 1'($urandom_range(1, 0));
      r1_valid = 1'($urandom_range(1, 0));
      sel = int'($urandom_range(9, 0));
      r0_addr = (sel == 0) ? RSV : (sel == 1) ? AW'(NPIX + sel) :
                AW'($urandom_range(NPIX - 1, 0));
      sel = int'($urandom_range(9, 0));
      r1_addr = (sel == 0) ? RSV : (sel == 1) ? AW'(NPIX) :
                AW'($urandom_range(NPIX - 1, 0));
      r0_data = DW'($urandom);
      r1_data = DW'($urandom);
      #1;
      if (r0_valid && r1_valid) want = exp_last ? 2'b01 : 2'b10;
      else want = {r1_valid, r0_valid};
      total++;
      if ({r1_ready, r0_ready} !== want) begin
        bad++;
        $display("FAIL rand_grant cycle=%0d got=%b want=%b",
                 i, {r1_ready, r0_ready}, want);
      end
      if (want == 2'b01) begin
        exp_last = 1'b0;
        if (r0_addr < AW'(NPIX)) exp_q.push_back('{a: r0_addr, d: r0_data});
        else exp_drop++;
      end else if (want == 2'b10) begin
        exp_last = 1'b1;
        if (r1_addr < AW'(NPIX)) exp_q.push_back('{a: r1_addr, d: r1_data});
        else exp_drop++;
      end
    end
    @(negedge clk);
    if (drop === 1'b1) seen_drop++;
    r0_valid = 1'b0; r1_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (drop === 1'b1) seen_drop++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rand_pending got=%0d want=0", exp_q.size());
    end
    total++;
    if (seen_drop != exp_drop) begin
      bad++;
      $display("FAIL rand_drops got=%0d want=%0d", seen_drop, exp_drop);
    end
  endtask

  initial begin
    rst = 1'b0;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
    clr_start = 1'b0; clr_data = '0;
    fork
      forever begin
        @(negedge clk);
        if (fb_we === 1'b1) begin
          total++;
          if (fb_addr === RSV) begin
            bad++;
            $display("FAIL reserved_addr got=%h want=not %h", fb_addr, RSV);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_port got a=%0d d=%h want=no write",
                     fb_addr, fb_data);
          end else begin
            m_e = exp_q.pop_front();
            if ({fb_addr, fb_data} !== {m_e.a, m_e.d}) begin
              bad++;
              $display("FAIL write_port got a=%0d d=%h want a=%0d d=%h",
                       fb_addr, fb_data, m_e.a, m_e.d);
            end
          end
        end
      end
    join_none
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_drop();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
